// File: rtl/pipe_add_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package    : pipe_add_pkg                                                |
// | Purpose    : Shared constants, stage-count helper and mode encoding for  |
// |              the pipelined adder/subtractor datapath.                    |
// | Contents   : C_DEF_WIDTH, C_DEF_CHUNK, nstages(), mode_e                 |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
package pipe_add_pkg;

  localparam int C_DEF_WIDTH = 32;
  localparam int C_DEF_CHUNK = 8;

  // Operation mode carried with every beat.
  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_SUB = 1'b1
  } mode_e;

  // One pipeline stage per CHUNK-bit slice.
  function automatic int nstages(input int width, input int chunk);
    return width / chunk;
  endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : chunk_adder                                                 |
// | Purpose    : Purely combinational CHUNK-bit ripple-carry adder built as  |
// |              a chain of full-adder cells.                                |
// | Ports      : a, b  (in)  CHUNK-bit addends                               |
// |              cin   (in)  carry into bit 0                                |
// |              sum   (out) CHUNK-bit sum                                   |
// |              cout  (out) carry out of the top bit                        |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module chunk_adder #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  // Each loop iteration is one full-adder cell; the local carry variable
  // threads the ripple chain without a self-referencing vector.
  always_comb begin : p_ripple
    logic v_c;
    v_c = cin;
    sum = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i] = a[i] ^ b[i] ^ v_c;
      v_c    = (a[i] & b[i]) | (v_c & (a[i] ^ b[i]));
    end
    cout = v_c;
  end

endmodule
`default_nettype wire

// File: rtl/pipe_add_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : pipe_add_sub                                                |
// | Purpose    : Pipelined ripple-carry adder/subtractor. A WIDTH-bit        |
// |              operation is split into CHUNK-bit slices, one per stage,    |
// |              with the carry registered between stages. Valid/ready on    |
// |              both sides with full backpressure.                          |
// | Ports      : clk, rst_n (async, active-low)                              |
// |              in_valid/in_ready, in_a, in_b, in_cin, in_sub  (operands)   |
// |              out_valid/out_ready, out_sum, out_cout, out_ovf (result)    |
// | Options    : PIPE_ADD_SUB_OVF_EN - when defined, out_ovf reports signed  |
// |              overflow; otherwise out_ovf is tied low.                    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module pipe_add_sub
  import pipe_add_pkg::*;
#(
  parameter int WIDTH = C_DEF_WIDTH,
  parameter int CHUNK = C_DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSTAGES = nstages(WIDTH, CHUNK);
  localparam int LAST    = NSTAGES - 1;

  logic [NSTAGES-1:0] w_vld;   // per-stage valid bits
  logic [NSTAGES-1:0] w_load;  // stage k takes new contents this edge
  mode_e              w_mode;

  assign w_mode = mode_e'(in_sub);

  // A stage may load when it is empty or its contents leave on this edge.
  // Walk from the output back to the input so each stage sees its
  // downstream neighbour's decision.
  always_comb begin : p_handshake
    logic v_down;
    v_down = out_ready;
    w_load = '0;
    for (int k = NSTAGES - 1; k >= 0; k--) begin
      w_load[k] = ~w_vld[k] | v_down;
      v_down    = w_load[k];
    end
  end

  assign in_ready = w_load[0];

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    // Stage k keeps only the operand slices it has not yet consumed.
    localparam int REM = (NSTAGES - k) * CHUNK;

    logic                   r_vld;
    logic                   r_cy;
    logic [REM-1:0]         r_a;
    logic [REM-1:0]         r_b;
    logic [CHUNK-1:0]       w_sum;
    logic                   w_cout;
    logic [(k+1)*CHUNK-1:0] w_done;  // slices 0..k of the result

    assign w_vld[k] = r_vld;

    chunk_adder #(
      .CHUNK (CHUNK)
    ) u_add (
      .a    (r_a[CHUNK-1:0]),
      .b    (r_b[CHUNK-1:0]),
      .cin  (r_cy),
      .sum  (w_sum),
      .cout (w_cout)
    );

    if (k == 0) begin : g_first
      assign w_done = w_sum;

      // Subtraction is A + ~B + 1: B is inverted and the carry forced high
      // at capture, so in_cin is ignored in that mode.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld <= 1'b0;
          r_cy  <= 1'b0;
          r_a   <= '0;
          r_b   <= '0;
        end else if (w_load[0]) begin
          r_vld <= in_valid;
          r_cy  <= (w_mode == MODE_SUB) ? 1'b1 : in_cin;
          r_a   <= in_a;
          r_b   <= (w_mode == MODE_SUB) ? ~in_b : in_b;
        end
      end
    end else begin : g_next
      logic [k*CHUNK-1:0] r_res;  // slices 0..k-1 already computed

      assign w_done = {w_sum, r_res};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_vld <= 1'b0;
          r_cy  <= 1'b0;
          r_a   <= '0;
          r_b   <= '0;
          r_res <= '0;
        end else if (w_load[k]) begin
          r_vld <= g_stage[k-1].r_vld;
          r_cy  <= g_stage[k-1].w_cout;
          r_a   <= g_stage[k-1].r_a[REM+CHUNK-1:CHUNK];
          r_b   <= g_stage[k-1].r_b[REM+CHUNK-1:CHUNK];
          r_res <= g_stage[k-1].w_done;
        end
      end
    end
  end

  // The last slice is added combinationally from held registers, so the
  // result stays stable for as long as the stage is stalled.
  assign out_valid = w_vld[LAST];
  assign out_sum   = g_stage[LAST].w_done;
  assign out_cout  = g_stage[LAST].w_cout;

`ifdef PIPE_ADD_SUB_OVF_EN
  // Carry into the MSB is recovered from the MSB sum bit: s = a ^ b ^ c_in.
  assign out_ovf = g_stage[LAST].w_cout
                 ^ g_stage[LAST].r_a[CHUNK-1]
                 ^ g_stage[LAST].r_b[CHUNK-1]
                 ^ g_stage[LAST].w_sum[CHUNK-1];
`else
  assign out_ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_add_sub.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module     : tb_pipe_add_sub                                             |
// | Purpose    : Directed self-checking bench for pipe_add_sub (32/8 build   |
// |              and a 16/16 single-stage build).                            |
// | Options    : PIPE_ADD_SUB_OVF_EN selects the expected out_ovf values.    |
// | Revision   : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module tb_pipe_add_sub;

`ifdef PIPE_ADD_SUB_OVF_EN
  localparam bit C_OVF = 1'b1;
`else
  localparam bit C_OVF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, in_cin, in_sub;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready, out_cout, out_ovf;
  logic [31:0] out_sum;

  logic        in_valid16, in_ready16, in_cin16, in_sub16;
  logic [15:0] in_a16, in_b16;
  logic        out_valid16, out_ready16, out_cout16, out_ovf16;
  logic [15:0] out_sum16;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_add_sub #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  pipe_add_sub #(.WIDTH(16), .CHUNK(16)) u_dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid16),
    .in_ready  (in_ready16),
    .in_a      (in_a16),
    .in_b      (in_b16),
    .in_cin    (in_cin16),
    .in_sub    (in_sub16),
    .out_valid (out_valid16),
    .out_ready (out_ready16),
    .out_sum   (out_sum16),
    .out_cout  (out_cout16),
    .out_ovf   (out_ovf16)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated beat into the 4-stage build; checks latency and result.
  task automatic beat(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic cin, input logic sub, input logic [31:0] e_sum,
                      input logic e_cout, input logic e_ovf);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check({tag, ".early"}, 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".sum"},   64'(out_sum),   64'(e_sum));
    check({tag, ".cout"},  64'(out_cout),  64'(e_cout));
    check({tag, ".ovf"},   64'(out_ovf),   64'(e_ovf));
    @(negedge clk);
    check({tag, ".drop"},  64'(out_valid), 64'd0);
  endtask

  initial begin : p_stim
    int          nsent, nrecv, cyc;
    logic [31:0] held;
    bit          stalled;

    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b1;
    in_valid16 = 1'b0; in_a16 = '0; in_b16 = '0; in_cin16 = 1'b0; in_sub16 = 1'b0;
    out_ready16 = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.sum",   64'(out_sum),   64'd0);
    check("rst.cout",  64'(out_cout),  64'd0);
    check("rst.ovf",   64'(out_ovf),   64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready", 64'(in_ready), 64'd1);

    // Directed single beats
    beat("add_ff_1",   32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    beat("add_carry",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    beat("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, C_OVF);
    beat("sub_borrow", 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    beat("sub_cin_ig", 32'h0000_000A, 32'h0000_0004, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0);
    beat("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, C_OVF);

    // Backpressure: 10 beats A=i,B=i, consumer stalled for the first 8 cycles
    nsent = 0; nrecv = 0; cyc = 0; held = '0; stalled = 1'b0;
    while (nrecv < 10 && cyc < 100) begin
      @(negedge clk);
      out_ready = (cyc >= 8);
      in_valid  = (nsent < 10);
      in_a = 32'(nsent); in_b = 32'(nsent); in_cin = 1'b0; in_sub = 1'b0;
      #1;
      if (cyc == 7) begin
        check("bp.accepts",  64'(nsent),    64'd4);
        check("bp.in_ready", 64'(in_ready), 64'd0);
        check("bp.valid",    64'(out_valid), 64'd1);
      end
      if (out_valid && !out_ready) begin
        if (stalled) check("bp.hold", 64'(out_sum), 64'(held));
        held = out_sum;
        stalled = 1'b1;
      end else begin
        stalled = 1'b0;
      end
      if (out_valid && out_ready) begin
        check("bp.order", 64'(out_sum), 64'(2 * nrecv));
        nrecv++;
      end
      if (in_valid && in_ready) nsent++;
      cyc++;
    end
    check("bp.received", 64'(nrecv), 64'd10);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("bp.empty", 64'(out_valid), 64'd0);

    // Mid-stream reset: 3 beats in flight, front beat held at the output
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = 32'h100 + 32'(i); in_b = 32'h1; in_cin = 1'b0; in_sub = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mrst.pre_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mrst.valid", 64'(out_valid), 64'd0);
    check("mrst.sum",   64'(out_sum),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("mrst.stale", 64'(out_valid), 64'd0);
    end
    beat("mrst.new", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    // Single-stage 16-bit build: back-to-back beats, latency 1
    @(negedge clk);
    check("w16.in_ready", 64'(in_ready16), 64'd1);
    in_valid16 = 1'b1; in_a16 = 16'h7FFF; in_b16 = 16'h0001; in_cin16 = 1'b0; in_sub16 = 1'b0;
    @(negedge clk);
    check("w16.b0.valid", 64'(out_valid16), 64'd1);
    check("w16.b0.sum",   64'(out_sum16),   64'h8000);
    check("w16.b0.cout",  64'(out_cout16),  64'd0);
    check("w16.b0.ovf",   64'(out_ovf16),   64'(C_OVF));
    in_a16 = 16'hFFFF; in_b16 = 16'h0001;
    @(negedge clk);
    in_valid16 = 1'b0;
    check("w16.b1.valid", 64'(out_valid16), 64'd1);
    check("w16.b1.sum",   64'(out_sum16),   64'h0000);
    check("w16.b1.cout",  64'(out_cout16),  64'd1);
    check("w16.b1.ovf",   64'(out_ovf16),   64'd0);
    @(negedge clk);
    check("w16.drop", 64'(out_valid16), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_add_sub.md
Name: pipe_add_sub

Overview:
- Parametrised, pipelined ripple-carry adder/subtractor.
- Next generation of the team's full-adder/half-adder datapath.
- Splits a WIDTH-bit operation into CHUNK-bit slices, one slice per pipeline stage, and registers the carry between stages.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides and full backpressure support.

Parameters:
- WIDTH, 32: operand and result width in bits. Must be a multiple of CHUNK.
- CHUNK, 8: bits added per stage. NSTAGES = WIDTH/CHUNK. NSTAGES >= 1.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_cin  in  1  carry-in. Ignored when in_sub=1.
- in_sub  in  1  0: A+B+cin. 1: A-B, computed as A+~B+1.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  result, modulo 2^WIDTH.
- out_cout  out  1  carry-out of the MSB. For subtraction, 1 means no borrow (A>=B unsigned).
- out_ovf  out  1  signed overflow. See Optional Feature.

Behaviour:
- Reset: async assert of rst_n clears every stage valid bit, carry register and data register. out_valid=0, out_sum=0, out_cout=0, out_ovf=0. in_ready=1 one cycle after rst_n deasserts (combinational from cleared valids).
- Transfer rule:
  - Input beat accepted on a clk edge where in_valid&in_ready.
  - Output beat consumed on a clk edge where out_valid&out_ready.
- Stage k (0..NSTAGES-1):
  - Holds a valid bit and the carry into slice k.
  - Holds slices 0..k-1 of the result already computed.
  - Holds unprocessed slices k..NSTAGES-1 of A and B. B is pre-inverted when sub=1.
- Stage advance: stage k loads from stage k-1 when stage k is empty or stage k's contents move on the same edge.
  - Last stage moves when out_ready=1.
  - in_ready = !valid0 | advance0.
- Stage k computes slice k as a CHUNK-bit add of A-slice, B-slice and the registered carry. Stage 0 uses the carry (in_sub ? 1 : in_cin).
- Latency: NSTAGES cycles from accept to out_valid with no stall. Throughput is one beat per cycle when out_ready=1.
- Stall: when out_ready=0 and the pipeline is full, in_ready=0. All stage registers hold. out_sum, out_cout and out_ovf are stable while out_valid=1 and out_ready=0.
- Bubbles: an empty stage does not block upstream. A bubble collapses on the next edge whenever a downstream stage is empty.
- Ordering: results emerge in acceptance order. No beat is dropped or duplicated.
- Simultaneous events: accept and consume on the same edge is legal when full, because everything shifts.
- Reset mid-operation: all in-flight beats are discarded. No partial result appears after reset.
- in_sub is captured with the beat. Mode may change every beat.
- NSTAGES=1 degenerates to a single-register adder with latency 1.

Optional Feature:
- Macro PIPE_ADD_SUB_OVF_EN.
- Defined: out_ovf = carry into MSB XOR carry out of MSB (two's-complement overflow for add and sub). It is registered with the final stage, so it has the same latency as out_sum.
- Undefined: out_ovf is tied 0 and no overflow logic or extra register is built.

Decomposition:
- Shared package pipe_add_pkg holds:
  - default WIDTH and CHUNK constants;
  - function nstages(WIDTH, CHUNK);
  - typedef for the mode encoding (ADD=0, SUB=1).
- One natural sub-module: chunk_adder (parameter CHUNK; inputs a, b, cin; outputs sum, cout). It is purely combinational, built as a CHUNK-long chain of full-adder cells and instantiated once per stage.
- Top-level owns all registers and handshake logic.

Test Plan:
- Reset, then one beat A=32'h0000_00FF, B=32'h0000_0001, cin=0, sub=0, out_ready=1 -> after 4 cycles out_valid=1, out_sum=32'h0000_0100, out_cout=0, out_ovf=0; then out_valid=0.
- Carry across all slices: A=32'hFFFF_FFFF, B=0, cin=1, add -> out_sum=0, out_cout=1, out_ovf=0.
- Subtract and signed overflow (macro on): A=32'h8000_0000, B=1, sub=1 -> out_sum=32'h7FFF_FFFF, out_cout=1, out_ovf=1. With macro off -> out_ovf=0. Also A=3, B=5, sub=1 -> out_sum=32'hFFFF_FFFE, out_cout=0.
- Backpressure: stream 10 beats (A=i, B=i) with out_ready=0 for 8 cycles, then 1 -> in_ready drops after 4 accepts; results 0,2,4,...,18 appear in order with none lost; out_sum is held stable during the stall.
- Mid-stream reset: 3 beats in flight, pulse rst_n low asynchronously between edges -> out_valid=0 immediately. No stale result appears after release. First new beat has latency 4.
- WIDTH=16, CHUNK=16 build: back-to-back beats 16'h7FFF+16'h0001 then 16'hFFFF+16'h0001 -> latency 1, results 16'h8000 (ovf=1) then 16'h0000 (cout=1).
